// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: the two raw pushbutton levels going in and the
// sequencing controls coming out to the counters, lap registers and HEX mux.
interface stopwatch_ctrl_if;
  logic       st_n;
  logic       lap_rstn;
  logic       tick;
  logic       running;
  logic       cnt_clr;
  logic       lap_capture;
  logic       disp_lap;
  logic [1:0] state;

  // Board side: drives the buttons, consumes the controls
  modport master (
    output st_n, lap_rstn,
    input  tick, running, cnt_clr, lap_capture, disp_lap, state
  );

  // Controller side
  modport slave (
    input  st_n, lap_rstn,
    output tick, running, cnt_clr, lap_capture, disp_lap, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: synchronises and debounces the start/stop and
// lap/reset buttons, runs the IDLE/RUN/PAUSE/LAP mode FSM and produces the
// tenth-second count enable plus clear, lap-capture and display-select.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 10,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PRESC_W = $clog2(DIV);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);
  localparam logic [DB_W-1:0]    DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  // Bit 0 is start/stop, bit 1 is lap/reset throughout the input path.
  logic [1:0]         w_btn;
  logic [1:0]         r_sync0;
  logic [1:0]         r_sync1;
  logic [1:0]         r_db;
  logic [1:0]         r_evt;
  logic [DB_W-1:0]    r_db_cnt [2];

  logic               w_st_evt;
  logic               w_lap_evt;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_init;
  logic               r_cnt_clr;
  logic               r_lap_cap;
  logic               w_cnt_clr_nxt;
  logic               w_lap_cap_nxt;

  logic [PRESC_W-1:0] r_presc;
  logic               w_running;
  logic               w_terminal;

  assign w_btn     = {bus.lap_rstn, bus.st_n};
  assign w_st_evt  = r_evt[0];
  assign w_lap_evt = r_evt[1];

  // Two-stage synchroniser, debounce counters and press-event detection.
  // The debounced level only moves after DEBOUNCE_CYCLES consecutive
  // synchronised samples disagree with it; one agreeing sample restarts
  // the count. Only the release->pressed (1->0) transition raises an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 2'b11;
      r_sync1 <= 2'b11;
      r_db    <= 2'b11;
      r_evt   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= {DB_W{1'b0}};
      end
    end else begin
      r_sync0 <= w_btn;
      r_sync1 <= r_sync0;
      for (int i = 0; i < 2; i++) begin
        r_evt[i] <= 1'b0;
        if (r_sync1[i] != r_db[i]) begin
          if (r_db_cnt[i] == DB_MAX) begin
            r_db[i]     <= r_sync1[i];
            r_db_cnt[i] <= {DB_W{1'b0}};
            r_evt[i]    <= ~r_sync1[i];
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
          end
        end else begin
          r_db_cnt[i] <= {DB_W{1'b0}};
        end
      end
    end
  end

  // Mode transitions and the one-cycle pulses that accompany them.
  // Start/stop has priority: a simultaneous lap event is dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr_nxt = r_init;
    w_lap_cap_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_st_evt) begin
          w_state_nxt = ST_RUN;
        end else if (w_lap_evt) begin
          w_cnt_clr_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_st_evt) begin
          w_state_nxt = ST_PAUSE;
        end else if (w_lap_evt) begin
          w_state_nxt   = ST_LAP;
          w_lap_cap_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LAP: begin
        if (w_st_evt) begin
          w_state_nxt = ST_RUN;
        end else if (w_lap_evt) begin
          w_lap_cap_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (w_st_evt) begin
          w_state_nxt = ST_RUN;
        end else if (w_lap_evt) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_clr_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_PAUSE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered pulses; r_init makes cnt_clr fire in
  // the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_init    <= 1'b1;
      r_cnt_clr <= 1'b0;
      r_lap_cap <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_init    <= 1'b0;
      r_cnt_clr <= w_cnt_clr_nxt;
      r_lap_cap <= w_lap_cap_nxt;
    end
  end

  assign w_running  = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_terminal = (r_presc == PRESC_MAX);

  // Tick prescaler: advances only while running, holds through PAUSE so
  // resuming neither loses nor adds a tick, and restarts on entry to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= {PRESC_W{1'b0}};
    end else if (w_state_nxt == ST_IDLE) begin
      r_presc <= {PRESC_W{1'b0}};
    end else if (w_running) begin
      if (w_terminal) begin
        r_presc <= {PRESC_W{1'b0}};
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end
    end else begin
      r_presc <= r_presc;
    end
  end

  assign bus.tick        = w_running & w_terminal;
  assign bus.running     = w_running;
  assign bus.cnt_clr     = r_cnt_clr;
  assign bus.lap_capture = r_lap_cap;
  assign bus.disp_lap    = (r_state == ST_LAP);
  assign bus.state       = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and a 4-sample debounce.
// Inputs change and outputs are sampled on the falling clock edge. With an
// input driven at falling edge N, the press event is registered at rising
// edge N+6 and the new state is visible at falling edge N+7.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_tick = 0;
  int   n_cap  = 0;
  int   n_clr  = 0;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .CLK_HZ          (100),
    .TICK_HZ         (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_tick = 0;
    n_cap  = 0;
    n_clr  = 0;
  endtask

  // Advance n falling edges, tallying output pulses seen at each.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) n_tick++;
      if (bus.lap_capture === 1'b1) n_cap++;
      if (bus.cnt_clr === 1'b1) n_clr++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.st_n     = 1'b1;
    bus.lap_rstn = 1'b1;

    // Reset values
    step(3);
    check2("rst_state", bus.state, 2'd0);
    check1("rst_running", bus.running, 1'b0);
    check1("rst_tick", bus.tick, 1'b0);
    check1("rst_lapcap", bus.lap_capture, 1'b0);
    check1("rst_displap", bus.disp_lap, 1'b0);
    rst = 1'b0;
    step(1);
    check1("clr_first", bus.cnt_clr, 1'b1);
    check2("clr_first_state", bus.state, 2'd0);
    step(1);
    check1("clr_second", bus.cnt_clr, 1'b0);
    clr_counts();
    step(48);
    checkn("idle_ticks", n_tick, 0);
    checkn("idle_clr", n_clr, 0);
    check2("idle_state", bus.state, 2'd0);
    check1("idle_displap", bus.disp_lap, 1'b0);

    // Start: IDLE -> RUN, ticks every 10 cycles from entry
    bus.st_n = 1'b0;
    step(6);
    check2("st1_pre", bus.state, 2'd0);
    step(1);
    check2("st1_run", bus.state, 2'd1);
    check1("st1_running", bus.running, 1'b1);
    check1("st1_tick0", bus.tick, 1'b0);
    clr_counts();
    step(3);
    bus.st_n = 1'b1;
    step(5);
    checkn("run_no_early_tick", n_tick, 0);
    step(1);
    check1("run_first_tick", bus.tick, 1'b1);
    clr_counts();
    step(9);
    checkn("run_gap", n_tick, 0);
    step(1);
    check1("run_second_tick", bus.tick, 1'b1);

    // Stop: RUN -> PAUSE, prescaler left at 6
    bus.st_n = 1'b0;
    clr_counts();
    step(6);
    check2("pause_pre", bus.state, 2'd1);
    checkn("pause_pre_ticks", n_tick, 0);
    step(1);
    check2("pause_enter", bus.state, 2'd2);
    check1("pause_running", bus.running, 1'b0);
    step(1);
    bus.st_n = 1'b1;
    clr_counts();
    step(20);
    checkn("pause_ticks", n_tick, 0);

    // Three-cycle glitch is rejected
    bus.st_n = 1'b0;
    step(3);
    bus.st_n = 1'b1;
    step(15);
    check2("glitch_state", bus.state, 2'd2);
    checkn("glitch_ticks", n_tick, 0);

    // Resume from prescaler 6: tick in the 4th RUN cycle
    bus.st_n = 1'b0;
    step(6);
    check2("resume_pre", bus.state, 2'd2);
    step(1);
    check2("resume_run", bus.state, 2'd1);
    check1("resume_tick0", bus.tick, 1'b0);
    clr_counts();
    step(2);
    checkn("resume_no_early", n_tick, 0);
    step(1);
    check1("resume_tick", bus.tick, 1'b1);
    bus.st_n = 1'b1;

    // Lap from RUN
    bus.lap_rstn = 1'b0;
    step(6);
    check2("lap_pre", bus.state, 2'd1);
    check1("lap_pre_cap", bus.lap_capture, 1'b0);
    step(1);
    check1("lap_cap1", bus.lap_capture, 1'b1);
    check2("lap_state", bus.state, 2'd3);
    check1("lap_displap", bus.disp_lap, 1'b1);
    check1("lap_running", bus.running, 1'b1);
    step(1);
    check1("lap_cap1_end", bus.lap_capture, 1'b0);
    bus.lap_rstn = 1'b1;
    clr_counts();
    step(12);
    checkn("lap_ticks", n_tick, 2);
    checkn("lap_held_no_cap", n_cap, 0);
    check2("lap_hold_state", bus.state, 2'd3);

    // Second lap press stays in LAP with a new capture
    bus.lap_rstn = 1'b0;
    step(6);
    check1("lap2_pre_cap", bus.lap_capture, 1'b0);
    step(1);
    check1("lap_cap2", bus.lap_capture, 1'b1);
    check2("lap2_state", bus.state, 2'd3);
    step(1);
    bus.lap_rstn = 1'b1;

    // Start/stop from LAP returns to live RUN
    bus.st_n = 1'b0;
    step(6);
    check2("lapexit_pre", bus.state, 2'd3);
    step(1);
    check2("lap_exit", bus.state, 2'd1);
    check1("lap_exit_displap", bus.disp_lap, 1'b0);
    check1("lap_exit_running", bus.running, 1'b1);
    step(1);
    bus.st_n = 1'b1;
    clr_counts();
    step(10);
    checkn("run_ticks3", n_tick, 1);

    // Pause with prescaler at 2, then lap -> IDLE with clear
    bus.st_n = 1'b0;
    step(6);
    check2("pause2_pre", bus.state, 2'd1);
    step(1);
    check2("pause2", bus.state, 2'd2);
    step(1);
    bus.st_n = 1'b1;
    bus.lap_rstn = 1'b0;
    step(6);
    check2("idle_ret_pre", bus.state, 2'd2);
    check1("idle_ret_pre_clr", bus.cnt_clr, 1'b0);
    step(1);
    check2("idle_return", bus.state, 2'd0);
    check1("idle_return_clr", bus.cnt_clr, 1'b1);
    step(1);
    check1("idle_return_clr_end", bus.cnt_clr, 1'b0);
    bus.lap_rstn = 1'b1;
    step(8);

    // New run starts from a cleared prescaler: tick in the 10th cycle
    bus.st_n = 1'b0;
    step(6);
    check2("rerun_pre", bus.state, 2'd0);
    step(1);
    check2("rerun", bus.state, 2'd1);
    clr_counts();
    step(3);
    bus.st_n = 1'b1;
    step(5);
    checkn("rerun_no_early", n_tick, 0);
    step(1);
    check1("rerun_tick10", bus.tick, 1'b1);

    // Simultaneous start/stop and lap events from RUN: start/stop wins
    bus.st_n     = 1'b0;
    bus.lap_rstn = 1'b0;
    clr_counts();
    step(6);
    check2("simul_pre", bus.state, 2'd1);
    step(1);
    check2("simul_state", bus.state, 2'd2);
    step(2);
    checkn("simul_no_cap", n_cap, 0);
    checkn("simul_no_clr", n_clr, 0);
    bus.st_n     = 1'b1;
    bus.lap_rstn = 1'b1;
    step(8);

    // Into LAP again
    bus.st_n = 1'b0;
    step(7);
    check2("to_run", bus.state, 2'd1);
    step(1);
    bus.st_n     = 1'b1;
    bus.lap_rstn = 1'b0;
    step(7);
    check2("to_lap", bus.state, 2'd3);
    step(1);
    bus.lap_rstn = 1'b1;

    // Reset during LAP with a press being debounced
    bus.st_n = 1'b0;
    step(4);
    bus.st_n = 1'b1;
    rst      = 1'b1;
    step(1);
    check2("rst2_state", bus.state, 2'd0);
    check1("rst2_running", bus.running, 1'b0);
    check1("rst2_displap", bus.disp_lap, 1'b0);
    check1("rst2_tick", bus.tick, 1'b0);
    check1("rst2_lapcap", bus.lap_capture, 1'b0);
    check1("rst2_clr_low", bus.cnt_clr, 1'b0);
    rst = 1'b0;
    step(1);
    check1("rst2_clr", bus.cnt_clr, 1'b1);
    step(1);
    check1("rst2_clr_end", bus.cnt_clr, 1'b0);
    clr_counts();
    step(15);
    check2("rst2_idle", bus.state, 2'd0);
    checkn("rst2_ticks", n_tick, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
